imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_word_packer.sv | 43 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the memory depth and the loader FSM state encoding.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler: shift register + 2-bit count.
// Ports: byte_in/byte_valid in, clear in, word (incl. current byte), word_full.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shifting in from the top leaves the first byte in bits 7:0
  // after four accepts; word already includes the byte being accepted.
  assign word      = byte_valid ? {byte_in, word_q[31:8]} : word_q;
  assign word_full = byte_valid && (cnt_q == 2'd3);

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_valid) begin
      word_d = word;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into instruction memory as 32-bit words, stalling fetch.
// Ports: start/len request, s_data/s_valid/s_ready stream, mem_* write, busy/done/err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  loader_state_e    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             pk_clear;
  logic             pk_full;
  logic [31:0]      pk_word;
  logic             acc;

  assign s_ready   = (state_q == ST_RECV);
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign acc       = s_valid && s_ready;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;

  word_packer u_pack (
    .clk        (clk),
    .rst_n      (reset),
    .byte_in    (s_data),
    .byte_valid (acc),
    .clear      (pk_clear),
    .word       (pk_word),
    .word_full  (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pk_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0 || int'(len) > DEPTH) begin
            err_d = 1'b1;
          end else begin
            len_d    = len;
            idx_d    = '0;
            pk_clear = 1'b1;
            state_d  = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        // Register the write on the 4th byte so mem_we
        // appears the cycle the FSM sits in WRITE.
        if (pk_full) begin
          we_d    = 1'b1;
          addr_d  = 32'(idx_q);
          wdata_d = pk_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pk_clear = 1'b1;
        if (idx_q == len_q - ONE) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ONE;
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed steps plus random loads.
// Expected writes come from a word list; monitor captures DUT writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(100), .LEN_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] exp_w[$];
  int we_cyc = 0;
  int done_cyc = 0;
  int done_n = 0;
  int err_n = 0;
  int overlap = 0;
  int rdy_we = 0;
  int busy_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      we_cyc <= cyc;
      if (s_ready) rdy_we <= rdy_we + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
      if (busy) busy_done <= busy_done + 1;
    end
    if (err) err_n <= err_n + 1;
    if (int'(mem_we) + int'(done) + int'(err) > 1)
      overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        32'({s_ready, mem_we, busy, done, err}), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 50) begin
      tick();
      t++;
    end
    if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic run_load(input int gap_max, input bit poke);
    int n;
    int wb;
    int db;
    int eb;
    int t;
    n  = exp_w.size();
    wb = wa.size();
    db = done_n;
    eb = err_n;
    start = 1'b1;
    len   = 7'(n);
    tick();
    start = 1'b0;
    len   = 7'($urandom);
    chk("busy_on_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (poke && i == 0 && b == 1) begin
          start = 1'b1;
          len   = 7'd5;
        end
        send_byte(exp_w[i][8*b +: 8],
                  gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
        start = 1'b0;
      end
    end
    if (poke) begin
      s_valid = 1'b1;
      s_data  = 8'hee;
      repeat (3) tick();
      s_valid = 1'b0;
    end
    t = 0;
    while (done_n == db && t < 20) begin
      tick();
      t++;
    end
    chk("done_cnt", 32'(done_n - db), 32'd1);
    chk("wr_cnt", 32'(wa.size() - wb), 32'(n));
    for (int i = 0; i < n && wb + i < wa.size(); i++) begin
      chk("wr_addr", wa[wb+i], 32'(i));
      chk("wr_data", wd[wb+i], exp_w[i]);
    end
    chk("we_latency", 32'(we_cyc), 32'(acc_cyc));
    chk("done_after_we", 32'(done_cyc), 32'(we_cyc + 1));
    chk("busy_idle", 32'(busy), 32'd0);
    chk("no_err", 32'(err_n - eb), 32'd0);
    tick();
  endtask

  initial begin
    int wb;
    int eb;
    int db;
    logic [31:0] w0;
    logic [31:0] w1;
    reset   = 1'b0;
    start   = 1'b0;
    len     = '0;
    s_data  = '0;
    s_valid = 1'b0;
    #1;
    chk_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_zero("post_reset");

    // two-word load, back-to-back bytes
    exp_w = '{32'h002081b3, 32'h00000562};
    run_load(0, 1'b0);

    // single word with 3 idle cycles between bytes
    exp_w = '{32'h00418298};
    begin
      wb = wa.size();
      start = 1'b1;
      len   = 7'd1;
      tick();
      start = 1'b0;
      send_byte(8'h98, 0);
      send_byte(8'h82, 3);
      send_byte(8'h41, 3);
      send_byte(8'h00, 3);
      repeat (3) tick();
      chk("bp_cnt", 32'(wa.size() - wb), 32'd1);
      if (wa.size() > wb) chk("bp_data", wd[wb], 32'h00418298);
      chk("bp_latency", 32'(we_cyc), 32'(acc_cyc));
    end

    // rejected lengths
    eb = err_n;
    wb = wa.size();
    db = done_n;
    start = 1'b1;
    len   = 7'd0;
    tick();
    start = 1'b0;
    chk("rej0_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b1;
    len   = 7'd101;
    tick();
    start = 1'b0;
    chk("rej101_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("rej_err_cnt", 32'(err_n - eb), 32'd2);
    chk("rej_no_wr", 32'(wa.size() - wb), 32'd0);
    chk("rej_no_done", 32'(done_n - db), 32'd0);

    // reset in the middle of a 3-word load
    w0 = $urandom;
    w1 = $urandom;
    wb = wa.size();
    start = 1'b1;
    len   = 7'd3;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8], 0);
    for (int b = 0; b < 2; b++) send_byte(w1[8*b +: 8], 0);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_zero("midrst_rel");
    chk("midrst_wr_cnt", 32'(wa.size() - wb), 32'd1);
    if (wa.size() > wb) begin
      chk("midrst_addr", wa[wb], 32'd0);
      chk("midrst_data", wd[wb], w0);
    end
    exp_w = '{32'($urandom)};
    run_load(0, 1'b0);

    // start during RECV and s_valid held through WRITE
    exp_w = '{32'($urandom)};
    run_load(0, 1'b1);
    chk("ready_in_write", 32'(rdy_we), 32'd0);

    // random loads with random gaps
    repeat (4) begin
      exp_w.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        exp_w.push_back($urandom);
      run_load(2, 1'b0);
    end

    // full depth
    exp_w.delete();
    for (int i = 0; i < 100; i++) exp_w.push_back(32'(i));
    wb = wa.size();
    run_load(0, 1'b0);
    repeat (5) tick();
    if (wa.size() > wb) chk("full_last_addr", wa[$], 32'd99);
    chk("full_no_extra", 32'(wa.size() - wb), 32'd100);

    chk("overlap", 32'(overlap), 32'd0);
    chk("busy_at_done", 32'(busy_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
